// File: rtl/resta_c2_segmentada.sv
// rtl/resta_c2_segmentada.sv - multi-cycle two's-complement subtractor, SEGMENTO bits per cycle
module resta_c2_segmentada #(
    parameter int ANCHO    = 64,
    parameter int SEGMENTO = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ANCHO-1:0] d,
    output logic             bout,
    output logic             desborde
);

    localparam int N     = ANCHO / SEGMENTO;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] CALCULO = 2'd1;
    localparam logic [1:0] ENTREGA = 2'd2;

    generate
        if ((SEGMENTO <= 0) || (ANCHO % SEGMENTO != 0)) begin : g_param_check
            $error("resta_c2_segmentada: SEGMENTO must divide ANCHO exactly");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [ANCHO-1:0] a_q, a_d;
    logic [ANCHO-1:0] nb_q, nb_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ANCHO-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             desborde_q, desborde_d;

    logic [SEGMENTO-1:0] seg_a, seg_nb;
    logic [SEGMENTO:0]   seg_sum;
    logic                ultimo;

    // Subtraction as a + ~b + ~bin; b is stored already inverted
    always_comb begin
        seg_a   = a_q[idx_q*SEGMENTO +: SEGMENTO];
        seg_nb  = nb_q[idx_q*SEGMENTO +: SEGMENTO];
        seg_sum = {1'b0, seg_a} + {1'b0, seg_nb} + {{SEGMENTO{1'b0}}, carry_q};
        ultimo  = (idx_q == IDX_W'(N - 1));
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        nb_d       = nb_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        d_d        = d_q;
        bout_d     = bout_q;
        desborde_d = desborde_q;
        case (state_q)
            OCIOSO: begin
                if (in_valid) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    idx_d   = '0;
                    state_d = CALCULO;
                end
            end
            CALCULO: begin
                d_d[idx_q*SEGMENTO +: SEGMENTO] = seg_sum[SEGMENTO-1:0];
                carry_d = seg_sum[SEGMENTO];
                idx_d   = idx_q + 1'b1;
                if (ultimo) begin
                    bout_d     = ~seg_sum[SEGMENTO];
                    desborde_d = (a_q[ANCHO-1] == nb_q[ANCHO-1]) &&
                                 (seg_sum[SEGMENTO-1] != a_q[ANCHO-1]);
                    idx_d      = '0;
                    state_d    = ENTREGA;
                end
            end
            ENTREGA: begin
                if (out_ready) begin
                    state_d = OCIOSO;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OCIOSO;
            a_q        <= '0;
            nb_q       <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            d_q        <= '0;
            bout_q     <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            nb_q       <= nb_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            d_q        <= d_d;
            bout_q     <= bout_d;
            desborde_q <= desborde_d;
        end
    end

    assign in_ready  = (state_q == OCIOSO);
    assign out_valid = (state_q == ENTREGA);
    assign d         = d_q;
    assign bout      = bout_q;
    assign desborde  = desborde_q;

endmodule

// File: tb/tb_resta_c2_segmentada.sv
// tb/tb_resta_c2_segmentada.sv - bench for resta_c2_segmentada against an arithmetic reference model
module tb_resta_c2_segmentada;

    localparam int ANCHO = 64;
    localparam int NSEG  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [ANCHO-1:0] a;
    logic [ANCHO-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [ANCHO-1:0] d;
    logic             bout;
    logic             desborde;

    int n_vec = 0;
    int n_bad = 0;

    resta_c2_segmentada #(.ANCHO(ANCHO), .SEGMENTO(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .desborde  (desborde)
    );

    always #5 clk = ~clk;

    // Reference: wide unsigned and signed subtraction
    task automatic model(input logic [ANCHO-1:0] ma, input logic [ANCHO-1:0] mb, input logic mbin,
                         output logic [ANCHO-1:0] md, output logic mbout, output logic movf);
        logic [ANCHO:0]          u;
        logic signed [ANCHO+1:0] s;
        u = {1'b0, ma} - {1'b0, mb} - {{ANCHO{1'b0}}, mbin};
        s = $signed({{2{ma[ANCHO-1]}}, ma}) - $signed({{2{mb[ANCHO-1]}}, mb})
            - $signed({{(ANCHO+1){1'b0}}, mbin});
        md    = u[ANCHO-1:0];
        mbout = u[ANCHO];
        movf  = (s > $signed({2'b00, 1'b0, {(ANCHO-1){1'b1}}})) ||
                (s < $signed({2'b11, 1'b1, {(ANCHO-1){1'b0}}}));
    endtask

    // Issues one operation, checks latency and result, then consumes it after `hold` stall cycles
    task automatic do_op(input logic [ANCHO-1:0] ta, input logic [ANCHO-1:0] tb_v, input logic tbin,
                         input int hold, input string name);
        logic [ANCHO-1:0] ed;
        logic             eb, eo;
        int               cnt;
        model(ta, tb_v, tbin, ed, eb, eo);
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_vec++;
        if (cnt != NSEG) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, cnt, NSEG);
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            n_vec++;
            if (d !== ed || bout !== eb || desborde !== eo || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s result (stall %0d): got d=%h bout=%b ovf=%b ov=%b ir=%b want d=%h bout=%b ovf=%b ov=1 ir=0",
                         name, h, d, bout, desborde, out_valid, in_ready, ed, eb, eo);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== ed) begin
            n_bad++;
            $display("FAIL %s after consume: got ov=%b ir=%b d=%h want ov=0 ir=1 d=%h",
                     name, out_valid, in_ready, d, ed);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== '0 || bout !== 1'b0 || desborde !== 1'b0) begin
            n_bad++;
            $display("FAIL reset state: got ir=%b ov=%b d=%h bout=%b ovf=%b want ir=1 ov=0 d=0 bout=0 ovf=0",
                     in_ready, out_valid, d, bout, desborde);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_op(64'd5, 64'd3, 1'b0, 0, "five_minus_three");
        do_op(64'd0, 64'd1, 1'b0, 0, "zero_minus_one");
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1, "min_minus_one");
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, "max_minus_neg1");
        do_op(64'h0000_0000_0001_0000, 64'd1, 1'b1, 0, "cross_segment_borrow");
        do_op(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, "zero_minus_all_ones_bin");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, "equal_with_bin");
    endtask

    task automatic test_random();
        logic [ANCHO-1:0] ra, rb;
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 5 == 0) rb = ra;
            if (i % 7 == 0) ra[ANCHO-1 -: 20] = '0;
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [ANCHO-1:0] ed;
        logic             eb, eo;
        int               cnt;
        model(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, ed, eb, eo);
        @(negedge clk);
        a = 64'h1234_5678_9ABC_DEF0; b = 64'hFEDC_BA98_7654_3210; bin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        for (int h = 0; h < 3; h++) begin
            if (h == 1) begin
                a = 64'd99; b = 64'd1; bin = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            n_vec++;
            if (d !== ed || bout !== eb || desborde !== eo || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL backpressure hold %0d: got d=%h bout=%b ovf=%b ir=%b ov=%b want d=%h bout=%b ovf=%b ir=0 ov=1",
                         h, d, bout, desborde, in_ready, out_valid, ed, eb, eo);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int h = 0; h < 8; h++) begin
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== ed) begin
                n_bad++;
                $display("FAIL ignored_pulse cycle %0d: got ov=%b ir=%b d=%h want ov=0 ir=1 d=%h",
                         h, out_valid, in_ready, d, ed);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = 64'hDEAD_BEEF_0000_1111; b = 64'h0123; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || d !== '0 || bout !== 1'b0 || desborde !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid immediate: got ov=%b d=%h bout=%b ovf=%b ir=%b want ov=0 d=0 bout=0 ovf=0 ir=1",
                     out_valid, d, bout, desborde, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int h = 0; h < 8; h++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== '0) begin
                n_bad++;
                $display("FAIL reset_mid after release cycle %0d: got ov=%b ir=%b d=%h want ov=0 ir=1 d=0",
                         h, out_valid, in_ready, d);
            end
        end
        do_op(64'd100, 64'd58, 1'b0, 0, "after_reset_op");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/resta_c2_segmentada.md
Name: resta_c2_segmentada

Overview:
- Multi-cycle two's-complement subtractor: d = a - b - bin, with unsigned borrow-out and signed overflow flag.
- Mirror operation of the team's combinational adder with carry-in and overflow; used by the datapath where subtraction timing must be broken into segments.
- Processes SEGMENTO bits per cycle over ANCHO/SEGMENTO cycles.
- Valid/ready handshake on both input and output; one operation in flight.

Parameters:
- ANCHO, 64, operand and result width in bits.
- SEGMENTO, 16, bits processed per cycle. Must divide ANCHO exactly; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and bin valid this cycle.
- in_ready  output  1  block can accept an operation.
- a  input  ANCHO  minuend, two's complement.
- b  input  ANCHO  subtrahend, two's complement.
- bin  input  1  borrow in.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer takes the result.
- d  output  ANCHO  difference, (a - b - bin) mod 2^ANCHO.
- bout  output  1  unsigned borrow out: 1 iff a < b + bin (unsigned).
- desborde  output  1  signed overflow: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]).

Behaviour:
- Reset (rst_n low, asynchronous): state OCIOSO, in_ready=1, out_valid=0, d=0, bout=0, desborde=0, segment index=0, internal operands and carry cleared.
- Reset mid-operation aborts the operation; no result is ever presented for it.
- Arithmetic: computed as a + ~b + ~bin.
  - Segment i covers bits [i*SEGMENTO +: SEGMENTO].
  - Carry out of segment i feeds segment i+1.
  - bout = NOT final carry.
  - desborde is computed from the captured a[MSB] and b[MSB] and the final d[MSB].
- State machine:
  - OCIOSO: in_ready=1, out_valid=0. On in_valid, capture a, ~b and carry=~bin; index=0; go to CALCULO.
  - CALCULO: in_ready=0. Each cycle, process segment[index], write its SEGMENTO result bits, update carry, index++. After the segment with index N-1 (N=ANCHO/SEGMENTO), latch bout and desborde and go to ENTREGA.
  - ENTREGA: out_valid=1, in_ready=0. d, bout and desborde stay stable until out_ready=1. On out_ready, go to OCIOSO.
- Latency: operation accepted at edge k; out_valid=1 after edge k+N (N=4 at defaults).
- Throughput: one operation per N+2 cycles minimum. The block does not accept a new operation in the same cycle a result is consumed.
- in_valid while in_ready=0 is ignored; inputs are not sampled outside OCIOSO.
- a, b and bin may change freely after acceptance.
- Outputs d, bout and desborde:
  - keep the last result after it is consumed, until the next operation overwrites them segment by segment;
  - are only meaningful while out_valid=1.
- N=1 (SEGMENTO=ANCHO) is legal: one CALCULO cycle.

Test Plan:
- a=5, b=3, bin=0 -> d=2, bout=0, desborde=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0, b=1, bin=0 -> d=0xFFFF_FFFF_FFFF_FFFF, bout=1, desborde=0.
- a=0x8000_0000_0000_0000, b=1, bin=0 -> d=0x7FFF_FFFF_FFFF_FFFF, bout=0, desborde=1.
- a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF, bin=0 -> d=0x8000_0000_0000_0000, bout=1, desborde=1.
- Cross-segment borrow: a=0x0000_0000_0001_0000, b=1, bin=1 -> d=0x0000_0000_0000_FFFE, bout=0, desborde=0.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles with in_valid=1 pulsed -> d, bout and desborde stable, in_ready=0, pulse ignored.
  - Assert rst_n=0 during CALCULO -> all outputs 0 immediately, in_ready=1 after release, no spurious out_valid.
